// File: rtl/echo_gen.sv
// Radar echo emulator: replays a delayed echo pulse for each tracking-unit trigger.
// Optional closing-target motion is built when ECHO_GEN_MOTION_EN is defined.
module echo_gen #(
    parameter int M_PER_CYCLE = 150,
    parameter int ECHO_WIDTH  = 4,
    parameter int MAX_DELAY   = 2000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic        radar_pulse_trigger,
    input  logic [31:0] target_distance,
    input  logic [31:0] range_step,
    output logic        radar_echo,
    output logic [31:0] current_range,
    output logic [15:0] echo_count,
    output logic        out_of_range,
    output logic [1:0]  gen_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        DELAY = 2'b10,
        ECHO  = 2'b11
    } state_t;

    localparam logic [31:0] M_DIV  = 32'(M_PER_CYCLE);
    localparam logic [31:0] D_MAX  = 32'(MAX_DELAY);
    localparam logic [31:0] W_ECHO = 32'(ECHO_WIDTH);

    state_t      state;
    logic [31:0] counter;
    logic        trig_r;
    logic        trig_d;
    logic        primed;
    logic        rise;
    logic        fall;
    logic        echo_done;
    logic [31:0] delay_calc;

    assign rise       = trig_r & ~trig_d;
    assign fall       = ~trig_r & trig_d;
    assign delay_calc = current_range / M_DIV;
    assign echo_done  = (state == ECHO) && enable && !rise && (counter == 32'd1);
    assign gen_state  = state;

`ifdef ECHO_GEN_MOTION_EN
    logic enable_d;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            enable_d      <= 1'b0;
            current_range <= target_distance;
        end else begin
            enable_d <= enable;
            if (enable && !enable_d) begin
                current_range <= target_distance;
            end else if (echo_done) begin
                current_range <= (current_range > range_step) ? (current_range - range_step) : 32'd0;
            end
        end
    end
`else
    logic unused_range_step;
    assign unused_range_step = ^range_step;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            current_range <= target_distance;
        end else if (rise) begin
            current_range <= target_distance;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            counter      <= '0;
            radar_echo   <= 1'b0;
            echo_count   <= '0;
            out_of_range <= 1'b0;
            trig_r       <= 1'b0;
            trig_d       <= 1'b0;
            primed       <= 1'b0;
        end else begin
            // First edge after reset loads both history taps, so a trigger
            // already high at release is never seen as a rise.
            trig_r <= radar_pulse_trigger;
            trig_d <= primed ? trig_r : radar_pulse_trigger;
            primed <= 1'b1;

            if (!enable) begin
                state      <= IDLE;
                radar_echo <= 1'b0;
                counter    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) state <= PULSE;
                    end
                    PULSE: begin
                        if (fall) begin
                            if (delay_calc > D_MAX) begin
                                out_of_range <= 1'b1;
                                state        <= IDLE;
                            end else begin
                                state   <= DELAY;
                                counter <= (delay_calc == 32'd0) ? 32'd1 : delay_calc;
                            end
                        end
                    end
                    DELAY: begin
                        if (rise) begin
                            state   <= PULSE;
                            counter <= '0;
                        end else if (counter == 32'd1) begin
                            state      <= ECHO;
                            radar_echo <= 1'b1;
                            counter    <= W_ECHO;
                        end else begin
                            counter <= counter - 32'd1;
                        end
                    end
                    ECHO: begin
                        if (rise) begin
                            state      <= PULSE;
                            radar_echo <= 1'b0;
                            counter    <= '0;
                        end else if (echo_done) begin
                            state      <= IDLE;
                            radar_echo <= 1'b0;
                            counter    <= '0;
                            echo_count <= echo_count + 16'd1;
                        end else begin
                            counter <= counter - 32'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/echo_gen.md
ECHO_GEN -- requirements
Module: echo_gen

Interface
REQ-001 Parameter: M_PER_CYCLE, default 150, metres of target range per clock cycle of round-trip delay (1 us CLK).
REQ-002 Parameter: ECHO_WIDTH, default 4, radar_echo high time in cycles (1..255).
REQ-003 Parameter: MAX_DELAY, default 2000, largest delay in cycles that still produces an echo.
REQ-004 Port: CLK  input  1  system clock; single clock domain; all state updates on rising edge.
REQ-005 Port: RST  input  1  asynchronous, active-low reset.
REQ-006 Port: enable  input  1  target present; low suppresses all echoes.
REQ-007 Port: radar_pulse_trigger  input  1  radar pulse from the tracking unit.
REQ-008 Port: target_distance  input  32  initial or static target range, metres.
REQ-009 Port: range_step  input  32  metres closed per echo; used only with motion enabled.
REQ-010 Port: radar_echo  output  1  emulated echo pulse.
REQ-011 Port: current_range  output  32  range used for the pending or last echo, metres.
REQ-012 Port: echo_count  output  16  echoes emitted since reset; wraps 0xFFFF->0.
REQ-013 Port: out_of_range  output  1  sticky; set when a computed delay exceeds MAX_DELAY.
REQ-014 Port: gen_state  output  2  00 IDLE, 01 PULSE, 10 DELAY, 11 ECHO.

Function
REQ-015 radar_pulse_trigger SHALL be registered once; rise/fall SHALL be detected from the registered value and its one-cycle-delayed copy.
REQ-016 IDLE: a detected rise with enable=1 SHALL move to PULSE on the next edge.
REQ-017 PULSE: a detected fall SHALL latch delay D = current_range / M_PER_CYCLE (unsigned integer division, 32-bit).
REQ-018 At that fall: D > MAX_DELAY -> set out_of_range, go IDLE; otherwise go DELAY with counter = max(D,1).
REQ-019 DELAY: counter SHALL decrement each cycle; at counter=1 the state SHALL go ECHO and radar_echo SHALL rise on that same edge.
REQ-020 Net latency: radar_echo rises exactly max(D,1) cycles after the edge that detected the fall.
REQ-021 ECHO: radar_echo SHALL stay high ECHO_WIDTH cycles, then drop; echo_count increments on the drop edge; state -> IDLE.
REQ-022 A detected rise in DELAY or ECHO SHALL abort the pending/active echo (radar_echo low next edge, no count) and enter PULSE.
REQ-023 enable low in any state SHALL force IDLE and radar_echo low on the next edge; no count increment.
REQ-024 Without motion, current_range SHALL load target_distance at every detected rise.
REQ-025 radar_echo SHALL be a direct register output, glitch-free.

Reset
REQ-026 RST low SHALL immediately clear: radar_echo=0, echo_count=0, out_of_range=0, gen_state=IDLE, counter=0, trigger history=0, current_range=target_distance.
REQ-027 Reset mid-PULSE/DELAY/ECHO SHALL discard the pending echo; a trigger already high at release SHALL NOT count as a rise.

Configuration
REQ-028 Macro ECHO_GEN_MOTION_EN defined: current_range loads target_distance only at reset and on enable rising; after each completed echo it decreases by range_step, saturating at 0.
REQ-029 Macro ECHO_GEN_MOTION_EN undefined: range_step ignored; REQ-024 applies; no subtraction logic instantiated.

Verification
REQ-030 target_distance=30000, 300-cycle trigger -> radar_echo rises 200 cycles after fall detect, high 4 cycles, echo_count=1.
REQ-031 target_distance=100 -> D=0, echo rises 1 cycle after fall detect.
REQ-032 target_distance=400000 -> D=2666 > 2000, no echo, out_of_range=1, gen_state=00.
REQ-033 Second trigger rise 2 cycles into ECHO -> radar_echo low next edge, echo_count unchanged, gen_state=01.
REQ-034 MOTION_EN, distance=30000, range_step=1500, two pulses -> second echo at 190 cycles, current_range=27000 after echo 2.
REQ-035 RST low during DELAY -> all outputs at reset values immediately, no echo after release.
